core_wb_sram: RTL and testbench

- Wishbone pipelined responder (slave) fronting a single-port on-chip SRAM of 32-bit words.
- Serves the core's memory access unit and any other pipelined bus master for LD/ST traffic.
- Accepts byte, halfword and word requests; queues up to QDEPTH outstanding requests; issues one ack or err per request, in order.
- Inserts a configurable number of wait states per request.

---
 rtl/core_wb_sram_if.sv | 23 ++
 rtl/core_wb_sram.sv | 216 +++++++++++++++++++++
 tb/tb_core_wb_sram.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_wb_sram_if.sv
// Pipelined Wishbone bus bundle shared by core_wb_sram (pl_slave view) and its bus masters (pl_master view).
interface wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_mo;
  logic [31:0] dat_so;
  logic        ack;
  logic        err;
  logic        stall;

  modport pl_master (
    output cyc, stb, we, sel, adr, dat_mo,
    input  dat_so, ack, err, stall
  );

  modport pl_slave (
    input  cyc, stb, we, sel, adr, dat_mo,
    output dat_so, ack, err, stall
  );
endinterface

// File: rtl/core_wb_sram.sv
// Pipelined Wishbone responder in front of a single-port 32-bit SRAM, with an in-order request queue and wait states.
// Define I2D_SRAM_ERR_EN to enable err responses for out-of-range addresses and illegal sel patterns.
module core_wb_sram #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0,
  parameter int QDEPTH      = 2
) (
  input  logic      clk,
  input  logic      rst,
  wishbone.pl_slave bus
);
  localparam int          PW   = $clog2(QDEPTH);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: sel_legal = 1'b1;
      default:                   sel_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [PW:0]          count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS-1:0] q_idx_q [QDEPTH];
  logic [ADDR_BITS-1:0] q_idx_d [QDEPTH];
  logic                 q_we_q  [QDEPTH];
  logic                 q_we_d  [QDEPTH];
  logic                 q_err_q [QDEPTH];
  logic                 q_err_d [QDEPTH];
  logic [3:0]           q_sel_q [QDEPTH];
  logic [3:0]           q_sel_d [QDEPTH];
  logic [31:0]          q_dat_q [QDEPTH];
  logic [31:0]          q_dat_d [QDEPTH];
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [31:0]          dat_so_q, dat_so_d;

  logic [31:0]          mem [2**ADDR_BITS];

  logic                 push_s;
  logic                 fire_s;
  logic                 q_empty_s;
  logic                 req_err_s;
  logic [ADDR_BITS-1:0] head_idx_s;
  logic                 head_we_s;
  logic                 head_err_s;
  logic [3:0]           head_sel_s;
  logic [31:0]          head_dat_s;
  logic [31:0]          head_rdata_s;

`ifdef I2D_SRAM_ERR_EN
  logic unused_adr_s;
  assign unused_adr_s = ^bus.adr[1:0];
  assign req_err_s    = (bus.adr[31:ADDR_BITS+2] != {(30-ADDR_BITS){1'b0}}) || !sel_legal(bus.sel);
`else
  // Upper address bits are dropped so the SRAM aliases across the address space.
  logic unused_adr_s;
  assign unused_adr_s = ^{bus.adr[31:ADDR_BITS+2], bus.adr[1:0]};
  assign req_err_s    = 1'b0;
`endif

  assign q_empty_s    = (count_q == {(PW+1){1'b0}});
  assign push_s       = bus.cyc && bus.stb && (count_q != FULL);
  // The head completes on this edge: straight from IDLE/RESP without wait states, else at the end of WAIT.
  assign fire_s       = bus.cyc &&
                        ((((state_q == ST_IDLE) || (state_q == ST_RESP)) && !q_empty_s && (WS == 4'd0)) ||
                         ((state_q == ST_WAIT) && (cnt_q == WS)));

  assign head_idx_s   = q_idx_q[rd_ptr_q];
  assign head_we_s    = q_we_q[rd_ptr_q];
  assign head_err_s   = q_err_q[rd_ptr_q];
  assign head_sel_s   = q_sel_q[rd_ptr_q];
  assign head_dat_s   = q_dat_q[rd_ptr_q];
  assign head_rdata_s = mem[head_idx_s] & lane_mask(head_sel_s);

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.dat_so   = dat_so_q;
  assign bus.stall    = (count_q == FULL);

  // Next-state logic for the queue, sequencing FSM and registered response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    q_idx_d  = q_idx_q;
    q_we_d   = q_we_q;
    q_err_d  = q_err_q;
    q_sel_d  = q_sel_q;
    q_dat_d  = q_dat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_so_d = dat_so_q;
    if (!bus.cyc) begin
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      count_d  = {(PW+1){1'b0}};
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
    end else begin
      if (push_s) begin
        q_idx_d[wr_ptr_q] = bus.adr[ADDR_BITS+1:2];
        q_we_d[wr_ptr_q]  = bus.we;
        q_err_d[wr_ptr_q] = req_err_s;
        q_sel_d[wr_ptr_q] = bus.sel;
        q_dat_d[wr_ptr_q] = bus.dat_mo;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (fire_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        ack_d    = !head_err_s;
        err_d    = head_err_s;
        dat_so_d = (head_err_s || head_we_s) ? 32'd0 : head_rdata_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, fire_s})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (fire_s) begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
          end else if (!q_empty_s) begin
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_WAIT: begin
          if (fire_s) begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      count_q  <= {(PW+1){1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_so_q <= 32'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_idx_q[i] <= {ADDR_BITS{1'b0}};
        q_we_q[i]  <= 1'b0;
        q_err_q[i] <= 1'b0;
        q_sel_q[i] <= 4'd0;
        q_dat_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_so_q <= dat_so_d;
      q_idx_q  <= q_idx_d;
      q_we_q   <= q_we_d;
      q_err_q  <= q_err_d;
      q_sel_q  <= q_sel_d;
      q_dat_q  <= q_dat_d;
    end
  end

  // SRAM byte-lane write at the completing edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (fire_s && head_we_s && !head_err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (head_sel_s[b]) begin
          mem[head_idx_s][8*b +: 8] <= head_dat_s[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_core_wb_sram.sv
// Directed bench for core_wb_sram: three instances with 0, 2 and 3 wait states checked against hand-computed values.
module tb_core_wb_sram;
  logic        clk = 1'b0;
  logic        rst;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc_n  = 0;
  int          err3_n = 0;
  int          log_cyc[$];
  logic [31:0] log_dat[$];

  wishbone wb0();
  wishbone wb2();
  wishbone wb3();

  core_wb_sram #(.ADDR_BITS(12), .WAIT_STATES(0), .QDEPTH(2)) u_dut0 (.clk(clk), .rst(rst), .bus(wb0));
  core_wb_sram #(.ADDR_BITS(12), .WAIT_STATES(2), .QDEPTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(wb2));
  core_wb_sram #(.ADDR_BITS(12), .WAIT_STATES(3), .QDEPTH(2)) u_dut3 (.clk(clk), .rst(rst), .bus(wb3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Response log of the 3-wait-state instance, stamped with the count of rising edges seen.
  always @(negedge clk) begin
    if (wb3.ack) begin
      log_cyc.push_back(cyc_n);
      log_dat.push_back(wb3.dat_so);
    end
    if (wb3.err) err3_n++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic set_req(input int d, input logic c, input logic s, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    case (d)
      0: begin wb0.cyc = c; wb0.stb = s; wb0.we = we; wb0.adr = adr; wb0.sel = sel; wb0.dat_mo = dat; end
      2: begin wb2.cyc = c; wb2.stb = s; wb2.we = we; wb2.adr = adr; wb2.sel = sel; wb2.dat_mo = dat; end
      default: begin wb3.cyc = c; wb3.stb = s; wb3.we = we; wb3.adr = adr; wb3.sel = sel; wb3.dat_mo = dat; end
    endcase
  endtask

  function automatic logic get_ack(input int d);
    case (d)
      0:       get_ack = wb0.ack;
      2:       get_ack = wb2.ack;
      default: get_ack = wb3.ack;
    endcase
  endfunction

  function automatic logic get_err(input int d);
    case (d)
      0:       get_err = wb0.err;
      2:       get_err = wb2.err;
      default: get_err = wb3.err;
    endcase
  endfunction

  function automatic logic [31:0] get_dat(input int d);
    case (d)
      0:       get_dat = wb0.dat_so;
      2:       get_dat = wb2.dat_so;
      default: get_dat = wb3.dat_so;
    endcase
  endfunction

  // One request on an idle bus; the instance number equals its wait-state count.
  task automatic xact(input int d, input string tag, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat,
                      input logic exp_ack, input logic exp_err, input logic [31:0] exp_dat);
    logic early;
    @(negedge clk);
    set_req(d, 1'b1, 1'b1, we, adr, sel, dat);
    @(posedge clk);
    @(negedge clk);
    set_req(d, 1'b1, 1'b0, we, adr, sel, dat);
    early = get_ack(d) | get_err(d);
    for (int k = 0; k < d; k++) begin
      @(negedge clk);
      early = early | get_ack(d) | get_err(d);
    end
    @(negedge clk);
    chk({tag, " early"}, 32'(early), 32'd0);
    chk({tag, " ack"}, 32'(get_ack(d)), 32'(exp_ack));
    chk({tag, " err"}, 32'(get_err(d)), 32'(exp_err));
    chk({tag, " dat"}, get_dat(d), exp_dat);
    @(negedge clk);
    chk({tag, " one-shot"}, 32'(get_ack(d) | get_err(d)), 32'd0);
  endtask

  initial begin
    int   i;
    int   guard;
    int   first_e;
    logic acc;
    logic stall2;
    logic quiet;

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(2, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(3, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset ack", 32'(wb0.ack), 32'd0);
    chk("reset err", 32'(wb0.err), 32'd0);
    chk("reset stall", 32'(wb0.stall), 32'd0);
    chk("reset dat_so", wb0.dat_so, 32'd0);
    chk("reset stall ws3", 32'(wb3.stall), 32'd0);

    xact(0, "wr word", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
    xact(0, "rd word", 1'b0, 32'h10, 4'hF, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
    xact(0, "wr byte2", 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 1'b1, 1'b0, 32'd0);
    xact(0, "rd merged", 1'b0, 32'h10, 4'hF, 32'd0, 1'b1, 1'b0, 32'hDEAABEEF);
    xact(0, "rd upper half", 1'b0, 32'h10, 4'b1100, 32'd0, 1'b1, 1'b0, 32'hDEAA0000);
    xact(0, "rd lane0 adr12", 1'b0, 32'h12, 4'b0001, 32'd0, 1'b1, 1'b0, 32'h000000EF);
    xact(0, "wr top word", 1'b1, 32'h3FFC, 4'hF, 32'h0BADCAFE, 1'b1, 1'b0, 32'd0);
    xact(0, "rd top word", 1'b0, 32'h3FFC, 4'hF, 32'd0, 1'b1, 1'b0, 32'h0BADCAFE);
`ifdef I2D_SRAM_ERR_EN
    xact(0, "rd out of range", 1'b0, 32'h0001_0000, 4'hF, 32'd0, 1'b0, 1'b1, 32'd0);
    xact(0, "wr bad sel", 1'b1, 32'h10, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0);
    xact(0, "rd after bad sel", 1'b0, 32'h10, 4'hF, 32'd0, 1'b1, 1'b0, 32'hDEAABEEF);
`else
    xact(0, "rd sel none", 1'b0, 32'h10, 4'h0, 32'd0, 1'b1, 1'b0, 32'd0);
    xact(0, "rd alias", 1'b0, 32'h0001_0010, 4'hF, 32'd0, 1'b1, 1'b0, 32'hDEAABEEF);
`endif

    for (int k = 0; k < 4; k++) begin
      xact(3, "ws3 preload", 1'b1, 32'h40 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k), 1'b1, 1'b0, 32'd0);
    end
    @(posedge clk);
    log_cyc.delete();
    log_dat.delete();
    err3_n  = 0;
    i       = 0;
    guard   = 0;
    first_e = -1;
    stall2  = 1'b0;
    @(negedge clk);
    while (i < 4 && guard < 64) begin
      guard++;
      set_req(3, 1'b1, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 4'hF, 32'd0);
      acc = !wb3.stall;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        i++;
        if (i == 1) first_e = cyc_n;
        if (i == 2) stall2 = wb3.stall;
      end
    end
    set_req(3, 1'b1, 1'b0, 1'b0, 32'd0, 4'hF, 32'd0);
    chk("stream accepts", 32'(i), 32'd4);
    chk("stall after 2 accepts", 32'(stall2), 32'd1);
    guard = 0;
    while (log_cyc.size() < 4 && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("stream ack count", 32'(log_cyc.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_cyc.size(); k++) begin
      chk("stream ack cycle", 32'(log_cyc[k] - first_e), 32'(4 * (k + 1)));
      chk("stream data", log_dat[k], 32'hA000_0000 + 32'(k));
    end
    chk("stream err count", 32'(err3_n), 32'd0);

    xact(2, "ws2 preload", 1'b1, 32'h84, 4'hF, 32'h55555555, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    set_req(2, 1'b1, 1'b1, 1'b1, 32'h80, 4'hF, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    set_req(2, 1'b1, 1'b1, 1'b1, 32'h84, 4'hF, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    set_req(2, 1'b1, 1'b0, 1'b0, 32'd0, 4'hF, 32'd0);
    guard = 0;
    while (!wb2.ack && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("flush first ack", 32'(wb2.ack), 32'd1);
    set_req(2, 1'b0, 1'b0, 1'b0, 32'd0, 4'hF, 32'd0);
    quiet = 1'b0;
    repeat (8) begin
      @(negedge clk);
      quiet = quiet | wb2.ack | wb2.err;
    end
    chk("flush no response", 32'(quiet), 32'd0);
    chk("flush stall", 32'(wb2.stall), 32'd0);
    xact(2, "rd84 after flush", 1'b0, 32'h84, 4'hF, 32'd0, 1'b1, 1'b0, 32'h55555555);
    xact(2, "rd80 after flush", 1'b0, 32'h80, 4'hF, 32'd0, 1'b1, 1'b0, 32'h12345678);

    @(negedge clk);
    set_req(2, 1'b1, 1'b1, 1'b0, 32'h80, 4'hF, 32'd0);
    @(posedge clk);
    @(negedge clk);
    set_req(2, 1'b1, 1'b0, 1'b0, 32'h80, 4'hF, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async rst ack", 32'(wb2.ack), 32'd0);
    chk("async rst err", 32'(wb2.err), 32'd0);
    chk("async rst stall", 32'(wb2.stall), 32'd0);
    chk("async rst dat_so", wb2.dat_so, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b0;
    repeat (8) begin
      @(negedge clk);
      quiet = quiet | wb2.ack | wb2.err;
    end
    chk("no ack after rst", 32'(quiet), 32'd0);
    xact(2, "rd after rst", 1'b0, 32'h80, 4'hF, 32'd0, 1'b1, 1'b0, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
